muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the RV32M extension. It sits in the EX stage beside the ALU and is fed the same decoded fields the ALU controller receives: Funct3, plus the operand values. The ID/EX control path asserts `start` only for Funct7 = 7'b0000001. The unit holds the pipeline via `busy` for the duration of a multi-cycle operation, then returns a registered result with a one-cycle `done` pulse.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants used by the EX-stage units.
package riscv_pkg;

   // Funct7 value that routes an R-type op to the mul/div unit
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // M-extension operation, keyed on Funct3
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per CALC cycle, with sign fix-up on the way out.
// Divide-by-zero and signed overflow bypass CALC and finish in one cycle.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   state_e         state, state_nxt;
   muldiv_op_e     op_q, op_in;
   logic [CW-1:0]  cnt;
   logic [WIDTH-1:0] hi_q, lo_q, opb_q;    // hi:lo is the accumulator / rem:quot pair
   logic           neg_q, rneg_q;          // product/quotient sign, remainder sign

   logic           sa, sb, a_neg, b_neg, div0, ovf, fast, launch;
   logic [WIDTH-1:0] fast_res, fin_res, hi_nxt, lo_nxt;
   logic [WIDTH:0] mul_sum, div_trial;
   logic           div_ge, last;

   // magnitude of a value that is optionally signed
   function automatic logic [WIDTH-1:0] magn(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   // optional two's-complement negate
   function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   // operand decode and the single-cycle special cases
   always_comb begin
      op_in    = muldiv_op_e'(Funct3);
      sa       = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
      sb       = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
      a_neg    = sa & SrcA[WIDTH-1];
      b_neg    = sb & SrcB[WIDTH-1];
      div0     = op_in[2] && (SrcB == '0);
      ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) && (SrcA == MOST_NEG) && (SrcB == '1);
      fast     = div0 | ovf;
      fast_res = '0;
      if (div0)     fast_res = op_in[1] ? SrcA : '1;
      else if (ovf) fast_res = op_in[1] ? '0 : MOST_NEG;
      launch   = (state == S_IDLE) && start && !flush;
   end

   // one iteration of shift-add (mul) or restoring subtract (div)
   always_comb begin
      mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
      div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
      div_ge    = !div_trial[WIDTH];
      if (op_q[2]) begin
         hi_nxt = div_ge ? div_trial[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
         lo_nxt = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         hi_nxt = mul_sum[WIDTH:1];
         lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      last = (cnt == CW'(WIDTH-1));
   end

   // final result with sign correction; upper half of -{hi,lo} is ~hi + (lo == 0)
   always_comb begin
      case (op_q)
         OP_MUL:                    fin_res = lo_nxt;
         OP_MULH, OP_MULHSU,
         OP_MULHU:                  fin_res = neg_q ? (~hi_nxt + {{(WIDTH-1){1'b0}}, (lo_nxt == '0)})
                                                    : hi_nxt;
         OP_DIV, OP_DIVU:           fin_res = cneg(lo_nxt, neg_q);
         default:                   fin_res = cneg(hi_nxt, rneg_q);
      endcase
   end

   // next-state logic; flush overrides everything
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (launch) state_nxt = fast ? S_DONE : S_CALC;
         S_CALC:  if (last)   state_nxt = S_DONE;
         S_DONE:              state_nxt = S_IDLE;
         default:             state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   assign busy = (state == S_CALC);
   assign done = (state == S_DONE);

   // state, operand latch, iteration and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         op_q   <= OP_MUL;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         opb_q  <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            op_q   <= op_in;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= magn(SrcA, sa);
            opb_q  <= magn(SrcB, sb);
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (fast) result <= fast_res;
         end else if (state == S_CALC && !flush) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            cnt  <= cnt + CW'(1);
            if (last) result <= fin_res;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
   import riscv_pkg::*;

   logic        clk, rst_n, start, flush, busy, done;
   logic [2:0]  Funct3;
   logic [31:0] SrcA, SrcB, result;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(rst_n), .start(start), .flush(flush), .Funct3(Funct3),
      .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive one start pulse; returns at the negedge of cycle 1 with start low
   task automatic launch(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp);
      @(negedge clk);
      Funct3 = op; SrcA = a; SrcB = b; start = 1'b1;
      if (push) exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b0;
   endtask

   // from cycle 1, follow busy until done; check busy profile, done cycle, result
   task automatic track(input string tag, input int done_cyc, input bit exp_busy);
      int cyc = 1;
      bit seen = 0;
      bit busy_ok = 1;
      logic [31:0] exp;
      while (cyc <= 40 && !seen) begin
         if (busy !== (exp_busy && cyc <= 32)) busy_ok = 0;
         if (done === 1'b1) seen = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check({tag, "_busy"}, 32'(busy_ok), 32'd1);
      check({tag, "_donecyc"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(done_cyc));
      if (seen) begin
         if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
         else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, result, exp);
         end
      end
   endtask

   // count cycles over a window in which busy and done must both stay low
   task automatic quiet(input string tag, input int n);
      bit ok = 1;
      for (int i = 0; i < n; i++) begin
         if (busy !== 1'b0 || done !== 1'b0) ok = 0;
         @(negedge clk);
      end
      check({tag, "_quiet"}, 32'(ok), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      rst_n = 1'b1;

      // main function
      launch(OP_MUL,    32'd7,        32'hFFFF_FFFD, 1, 32'hFFFF_FFEB); track("mul",    33, 1);
      launch(OP_MULH,   32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000); track("mulh",   33, 1);
      launch(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE); track("mulhu",  33, 1);
      launch(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        1, 32'hFFFF_FFFF); track("mulhsu", 33, 1);
      launch(OP_DIV,    32'hFFFF_FFF9, 32'd2,        1, 32'hFFFF_FFFD); track("div",    33, 1);
      launch(OP_REM,    32'hFFFF_FFF9, 32'd2,        1, 32'hFFFF_FFFF); track("rem",    33, 1);
      launch(OP_DIVU,   32'd100,      32'd7,        1, 32'd14);        track("divu",   33, 1);
      launch(OP_REMU,   32'd100,      32'd7,        1, 32'd2);         track("remu",   33, 1);

      // flush in cycle 10 of a DIV: result must keep the REMU value
      launch(OP_DIV, 32'd1000, 32'd3, 0, '0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_c11", 32'(busy), 32'd0);
      quiet("flush_calc", 35);
      check("flush_result_kept", result, 32'd2);

      // fast path, with a start offered in the DONE cycle that must be ignored
      launch(OP_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF); track("divu_by0", 1, 0);
      Funct3 = OP_MUL; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      quiet("start_in_done", 5);
      check("start_in_done_result", result, 32'hFFFF_FFFF);

      launch(OP_REM, 32'd5,         32'd0,         1, 32'd5);         track("rem_by0",  1, 0);
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000); track("div_ovf",  1, 0);
      launch(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);         track("rem_ovf",  1, 0);

      // start together with flush in IDLE: neither normal nor fast op launches
      @(negedge clk);
      Funct3 = OP_DIVU; SrcA = 32'd50; SrcB = 32'd5; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      quiet("startflush_norm", 3);
      Funct3 = OP_DIVU; SrcA = 32'd50; SrcB = 32'd0; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      quiet("startflush_fast", 3);
      check("startflush_result", result, 32'd0);

      // flush in the DONE cycle: done is already committed
      launch(OP_REMU, 32'd23, 32'd0, 1, 32'd23);
      flush = 1'b1;
      track("flush_in_done", 1, 0);
      @(negedge clk);
      flush = 1'b0;
      quiet("after_flush_done", 3);

      // async reset in cycle 5 of a MUL
      launch(OP_MUL, 32'd11, 32'd13, 0, '0);
      repeat (4) @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet("post_reset", 35);

      launch(OP_MUL, 32'd3, 32'd4, 1, 32'd12); track("mul_after_rst", 33, 1);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
